// File: rtl/i2c_codec_config_seq.sv
// WM8731 configuration sequencer: 500 kHz timing plus an 11-word register walk for the I2C serializer.
// Optional macro I2C_WATCHDOG_EN adds a per-word timeout with one retry and a sticky I2C_TIMEOUT flag.
module i2c_codec_config_seq #(
   parameter int          CLK_DIV       = 50,
   parameter logic [7:0]  SLAVE_ADDR    = 8'h34,
   parameter logic [15:0] POWERUP_TICKS = 16'd2000,
   parameter logic [7:0]  GAP_TICKS     = 8'd16,
   parameter bit          AUTO_START    = 1'b1
) (
   input  logic        CLOCK_50,
   input  logic        RESET,
   input  logic        START,
   input  logic        NEXT_WORD,
   output logic        CLOCK_500,
   output logic        CLOCK_500_ena,
   output logic        CLOCK_SDAT_ena,
   output logic        TRANSACTION_REQ,
   output logic [23:0] I2C_DATA,
   output logic [3:0]  REG_INDEX,
   output logic        BUSY,
   output logic        CONFIG_DONE,
   output logic        I2C_TIMEOUT
);

   localparam int DIV_W = $clog2(CLK_DIV + 1);

   typedef enum logic [2:0] {IDLE, POWERUP, LOAD, XFER, GAP, DONE} state_t;

   state_t            state, state_next;
   logic [DIV_W-1:0]  div_cnt;
   logic              clk500_q, rise_q, fall_q;
   logic [15:0]       wait_cnt, wait_next;
   logic [3:0]        reg_idx, idx_next;
   logic [23:0]       data_q, data_next;
   logic              req_q, req_next;
   logic              done_q, done_next;
   logic              busy_q, busy_next;
   logic              launch;

`ifdef I2C_WATCHDOG_EN
   logic [5:0]        wd_cnt, wd_next;
   logic              retried, retried_next;
   logic              timeout_q, timeout_next;
`endif

   // Register table: {reg_addr[6:0], data[8:0]}
   function automatic logic [15:0] table_word(input logic [3:0] idx);
      case (idx)
         4'd0:    table_word = {7'h0F, 9'h000};
         4'd1:    table_word = {7'h00, 9'h017};
         4'd2:    table_word = {7'h01, 9'h017};
         4'd3:    table_word = {7'h02, 9'h079};
         4'd4:    table_word = {7'h03, 9'h079};
         4'd5:    table_word = {7'h04, 9'h012};
         4'd6:    table_word = {7'h05, 9'h000};
         4'd7:    table_word = {7'h06, 9'h000};
         4'd8:    table_word = {7'h07, 9'h002};
         4'd9:    table_word = {7'h08, 9'h000};
         4'd10:   table_word = {7'h09, 9'h001};
         default: table_word = 16'h0000;
      endcase
   endfunction

   // Free-running divider; the edge pulses are registered alongside the toggle
   always_ff @(posedge CLOCK_50 or negedge RESET) begin
      if (!RESET) begin
         div_cnt  <= '0;
         clk500_q <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
         div_cnt  <= '0;
         clk500_q <= ~clk500_q;
         rise_q   <= ~clk500_q;
         fall_q   <= clk500_q;
      end else begin
         div_cnt  <= div_cnt + 1'b1;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESET) begin
      if (!RESET) begin
         state    <= IDLE;
         wait_cnt <= '0;
         reg_idx  <= '0;
         data_q   <= '0;
         req_q    <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
`ifdef I2C_WATCHDOG_EN
         wd_cnt    <= '0;
         retried   <= 1'b0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state    <= state_next;
         wait_cnt <= wait_next;
         reg_idx  <= idx_next;
         data_q   <= data_next;
         req_q    <= req_next;
         done_q   <= done_next;
         busy_q   <= busy_next;
`ifdef I2C_WATCHDOG_EN
         wd_cnt    <= wd_next;
         retried   <= retried_next;
         timeout_q <= timeout_next;
`endif
      end
   end

   always_comb begin
      state_next = state;
      wait_next  = wait_cnt;
      idx_next   = reg_idx;
      data_next  = data_q;
      req_next   = req_q;
      done_next  = done_q;
      launch     = 1'b0;
`ifdef I2C_WATCHDOG_EN
      wd_next      = wd_cnt;
      retried_next = retried;
      timeout_next = timeout_q;
`endif
      case (state)
         IDLE: begin
            idx_next = '0;
            launch   = START || AUTO_START;
         end
         POWERUP: begin
            if (wait_cnt == 16'd0)
               state_next = LOAD;
            else if (fall_q)
               wait_next = wait_cnt - 16'd1;
         end
         LOAD: begin
            data_next  = {SLAVE_ADDR, table_word(reg_idx)};
            req_next   = 1'b1;
            state_next = XFER;
`ifdef I2C_WATCHDOG_EN
            wd_next = '0;
`endif
         end
         XFER: begin
            if (NEXT_WORD) begin
               req_next   = 1'b0;
               state_next = GAP;
               wait_next  = {8'd0, GAP_TICKS};
`ifdef I2C_WATCHDOG_EN
               retried_next = 1'b0;
            end else if (fall_q) begin
               if (wd_cnt == 6'd63) begin
                  // First timeout retries the same word, second one gives up
                  req_next = 1'b0;
                  if (retried) begin
                     timeout_next = 1'b1;
                     state_next   = DONE;
                  end else begin
                     retried_next = 1'b1;
                     state_next   = GAP;
                     wait_next    = {8'd0, GAP_TICKS};
                  end
               end else begin
                  wd_next = wd_cnt + 6'd1;
               end
`endif
            end
         end
         GAP: begin
            if (wait_cnt == 16'd0) begin
`ifdef I2C_WATCHDOG_EN
               if (retried)
                  state_next = LOAD;
               else
`endif
               if (reg_idx == 4'd10) begin
                  state_next = DONE;
                  done_next  = 1'b1;
               end else begin
                  idx_next   = reg_idx + 4'd1;
                  state_next = LOAD;
               end
            end else if (fall_q) begin
               wait_next = wait_cnt - 16'd1;
            end
         end
         DONE: begin
            req_next = 1'b0;
            launch   = START;
         end
         default: state_next = IDLE;
      endcase

      if (launch) begin
         state_next = POWERUP;
         wait_next  = POWERUP_TICKS;
         idx_next   = '0;
         done_next  = 1'b0;
`ifdef I2C_WATCHDOG_EN
         timeout_next = 1'b0;
         retried_next = 1'b0;
`endif
      end

      busy_next = (state_next != IDLE) && (state_next != DONE);
   end

   assign CLOCK_500       = clk500_q;
   assign CLOCK_500_ena   = rise_q;
   assign CLOCK_SDAT_ena  = fall_q;
   assign TRANSACTION_REQ = req_q;
   assign I2C_DATA        = data_q;
   assign REG_INDEX       = reg_idx;
   assign BUSY            = busy_q;
   assign CONFIG_DONE     = done_q;
`ifdef I2C_WATCHDOG_EN
   assign I2C_TIMEOUT     = timeout_q;
`else
   assign I2C_TIMEOUT     = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_codec_config_seq.sv
// Scoreboard bench for i2c_codec_config_seq: expected words are queued per run and popped on each REQ rise.
module tb_i2c_codec_config_seq;

   localparam int          CLK_DIV    = 10;
   localparam logic [15:0] PWR_TICKS  = 16'd20;
   localparam logic [7:0]  GAP_TICKS  = 8'd16;
   localparam int          RESP_TICKS = 40;
   localparam int          BOUND      = 8000;

   logic        CLOCK_50 = 1'b0;
   logic        RESET = 1'b0;
   logic        START = 1'b0;
   logic        NEXT_WORD = 1'b0;
   logic        CLOCK_500, CLOCK_500_ena, CLOCK_SDAT_ena;
   logic        TRANSACTION_REQ, BUSY, CONFIG_DONE, I2C_TIMEOUT;
   logic [23:0] I2C_DATA;
   logic [3:0]  REG_INDEX;

   int          checkCount = 0;
   int          passCount = 0;
   int          cyc = 0;
   int          gapTicks = 0;
   logic        prevReq = 1'b0;
   logic [23:0] lastWord = '0;
   logic [23:0] expQ[$];

   logic [6:0]  modelReg[11] = '{7'd15, 7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7, 7'd8, 7'd9};
   logic [8:0]  modelVal[11] = '{9'h000, 9'h017, 9'h017, 9'h079, 9'h079, 9'h012,
                                 9'h000, 9'h000, 9'h002, 9'h000, 9'h001};

   i2c_codec_config_seq #(
      .CLK_DIV(CLK_DIV), .SLAVE_ADDR(8'h34), .POWERUP_TICKS(PWR_TICKS),
      .GAP_TICKS(GAP_TICKS), .AUTO_START(1'b1)
   ) dut (
      .CLOCK_50(CLOCK_50), .RESET(RESET), .START(START), .NEXT_WORD(NEXT_WORD),
      .CLOCK_500(CLOCK_500), .CLOCK_500_ena(CLOCK_500_ena), .CLOCK_SDAT_ena(CLOCK_SDAT_ena),
      .TRANSACTION_REQ(TRANSACTION_REQ), .I2C_DATA(I2C_DATA), .REG_INDEX(REG_INDEX),
      .BUSY(BUSY), .CONFIG_DONE(CONFIG_DONE), .I2C_TIMEOUT(I2C_TIMEOUT)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) cyc = cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected)
         passCount++;
      else
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
   endtask

   function automatic logic [23:0] modelWord(input int i);
      return {8'h34, modelReg[i], modelVal[i]};
   endfunction

   // Each REQ rise must match the head of the expected queue and follow enough idle ticks
   always @(negedge CLOCK_50) begin
      if (!RESET) begin
         prevReq  = 1'b0;
         gapTicks = 0;
      end else begin
         if (!TRANSACTION_REQ && prevReq) gapTicks = 0;
         if (CLOCK_SDAT_ena && !TRANSACTION_REQ) gapTicks++;
         if (TRANSACTION_REQ && !prevReq) begin
            checkOutput("gap_ticks", 32'(gapTicks >= int'(GAP_TICKS)), 32'd1);
            checkOutput("word_expected", 32'(expQ.size() > 0), 32'd1);
            if (expQ.size() > 0) checkOutput("word_data", 32'(I2C_DATA), 32'(expQ.pop_front()));
            lastWord = I2C_DATA;
         end
         prevReq = TRANSACTION_REQ;
      end
   end

   task automatic applyStimulus(input logic s, input logic n);
      @(negedge CLOCK_50);
      START = s;
      NEXT_WORD = n;
      @(negedge CLOCK_50);
      START = 1'b0;
      NEXT_WORD = 1'b0;
   endtask

   task automatic waitTicks(input int k);
      int c = 0;
      while (c < k) begin
         @(negedge CLOCK_50);
         if (CLOCK_SDAT_ena) c++;
      end
   endtask

   task automatic waitReq(output bit ok);
      int n = 0;
      while (!TRANSACTION_REQ && n < BOUND) begin
         @(negedge CLOCK_50);
         n++;
      end
      ok = TRANSACTION_REQ;
      if (!ok) checkOutput("req_rise", 32'(TRANSACTION_REQ), 32'd1);
   endtask

   task automatic serveWord(input int idx, output bit ok);
      waitReq(ok);
      if (ok) begin
         checkOutput("reg_index", 32'(REG_INDEX), 32'(idx));
         checkOutput("busy_xfer", 32'(BUSY), 32'd1);
         waitTicks(RESP_TICKS);
         checkOutput("data_stable", 32'(I2C_DATA), 32'(lastWord));
         applyStimulus(1'b0, 1'b1);
         checkOutput("req_drop", 32'(TRANSACTION_REQ), 32'd0);
      end
   endtask

   task automatic pushRun();
      for (int i = 0; i < 11; i++) expQ.push_back(modelWord(i));
   endtask

   task automatic waitDone();
      int n = 0;
      while (!CONFIG_DONE && n < BOUND) begin
         @(negedge CLOCK_50);
         n++;
      end
      checkOutput("config_done", 32'(CONFIG_DONE), 32'd1);
      checkOutput("busy_done", 32'(BUSY), 32'd0);
      checkOutput("index_done", 32'(REG_INDEX), 32'd10);
      checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_clk500"}, 32'(CLOCK_500), 32'd0);
      checkOutput({tag, "_ena"}, 32'({CLOCK_500_ena, CLOCK_SDAT_ena}), 32'd0);
      checkOutput({tag, "_req"}, 32'(TRANSACTION_REQ), 32'd0);
      checkOutput({tag, "_data"}, 32'(I2C_DATA), 32'd0);
      checkOutput({tag, "_index"}, 32'(REG_INDEX), 32'd0);
      checkOutput({tag, "_busy"}, 32'(BUSY), 32'd0);
      checkOutput({tag, "_done"}, 32'(CONFIG_DONE), 32'd0);
      checkOutput({tag, "_timeout"}, 32'(I2C_TIMEOUT), 32'd0);
   endtask

   task automatic waitEna(input bit sdat);
      int n = 0;
      do begin
         @(negedge CLOCK_50);
         n++;
      end while (!(sdat ? CLOCK_SDAT_ena : CLOCK_500_ena) && n < 4 * CLK_DIV);
   endtask

   initial begin
      bit ok;
      int t0, t1, t2;
      repeat (3) @(negedge CLOCK_50);
      checkResetValues("reset");
      pushRun();
      RESET = 1'b1;

      // Divider timing
      waitEna(1'b0);
      t0 = cyc;
      checkOutput("clk500_high", 32'(CLOCK_500), 32'd1);
      @(negedge CLOCK_50);
      checkOutput("ena_width", 32'(CLOCK_500_ena), 32'd0);
      waitEna(1'b1);
      t1 = cyc;
      checkOutput("rise_to_fall", 32'(t1 - t0), 32'(CLK_DIV));
      checkOutput("clk500_low", 32'(CLOCK_500), 32'd0);
      @(negedge CLOCK_50);
      checkOutput("sdat_width", 32'(CLOCK_SDAT_ena), 32'd0);
      waitEna(1'b0);
      t2 = cyc;
      checkOutput("clk500_period", 32'(t2 - t0), 32'(2 * CLK_DIV));

      // Stray NEXT_WORD during POWERUP
      checkOutput("busy_powerup", 32'(BUSY), 32'd1);
      applyStimulus(1'b0, 1'b1);
      checkOutput("powerup_index", 32'(REG_INDEX), 32'd0);
      checkOutput("powerup_req", 32'(TRANSACTION_REQ), 32'd0);

      for (int i = 0; i < 11; i++) begin
         serveWord(i, ok);
         if (i == 0) begin
            waitTicks(3);
            applyStimulus(1'b0, 1'b1);
            checkOutput("gap_stray_index", 32'(REG_INDEX), 32'd0);
            checkOutput("gap_stray_req", 32'(TRANSACTION_REQ), 32'd0);
         end
         if (i == 2) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("start_ignored", 32'(REG_INDEX), 32'd2);
            checkOutput("start_ignored_busy", 32'(BUSY), 32'd1);
         end
      end
      waitDone();

      // START from DONE reruns, then reset lands in word 5
      applyStimulus(1'b1, 1'b0);
      checkOutput("restart_done", 32'(CONFIG_DONE), 32'd0);
      checkOutput("restart_busy", 32'(BUSY), 32'd1);
      checkOutput("restart_index", 32'(REG_INDEX), 32'd0);
      pushRun();
      for (int i = 0; i < 5; i++) serveWord(i, ok);
      waitReq(ok);
      checkOutput("word5_index", 32'(REG_INDEX), 32'd5);
      waitTicks(5);
      RESET = 1'b0;
      #1;
      checkResetValues("midreset");
      expQ.delete();
      pushRun();
      repeat (3) @(negedge CLOCK_50);
      RESET = 1'b1;
      for (int i = 0; i < 11; i++) serveWord(i, ok);
      waitDone();

`ifdef I2C_WATCHDOG_EN
      // Silent serializer: word 0 twice, then give up
      @(negedge CLOCK_50);
      RESET = 1'b0;
      expQ.delete();
      expQ.push_back(modelWord(0));
      expQ.push_back(modelWord(0));
      repeat (2) @(negedge CLOCK_50);
      RESET = 1'b1;
      begin
         int n = 0;
         while (!I2C_TIMEOUT && n < BOUND) begin
            @(negedge CLOCK_50);
            n++;
         end
      end
      checkOutput("wd_timeout", 32'(I2C_TIMEOUT), 32'd1);
      checkOutput("wd_done", 32'(CONFIG_DONE), 32'd0);
      checkOutput("wd_busy", 32'(BUSY), 32'd0);
      checkOutput("wd_req", 32'(TRANSACTION_REQ), 32'd0);
      checkOutput("wd_words", 32'(expQ.size()), 32'd0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("wd_clear", 32'(I2C_TIMEOUT), 32'd0);
      checkOutput("wd_restart_busy", 32'(BUSY), 32'd1);
`else
      checkOutput("timeout_tied", 32'(I2C_TIMEOUT), 32'd0);
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
